move_commit: RTL and testbench

//  Board-side consumer of the AI move interface and owner of game state. Accepts human cell

---
 rtl/move_commit.sv | 161 ++++++++++++++++
 tb/tb_move_commit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_commit.sv
// Board-side game controller for the tic-tac-toe AI link: takes human presses and AI moves,
// commits legal ones into the X/O boards, detects win/draw and sequences turns.
module move_commit #(
    parameter bit HUMAN_FIRST = 1'b1,
    parameter int AI_TIMEOUT  = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       new_game_i,
    input  logic [8:0] btn_i,
    input  logic [8:0] ai_move_i,
    output logic       ai_turn_o,
    output logic [8:0] x_board_o,
    output logic [8:0] o_board_o,
    output logic [8:0] occ_o,
    output logic [1:0] winner_o,
    output logic       game_over_o,
    output logic       illegal_o,
    output logic       ai_fault_o
);

    localparam int TW = $clog2(AI_TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(AI_TIMEOUT - 1);

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_HUMAN = 2'b01;
    localparam logic [1:0] WIN_AI    = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

    // Bit 8 = cell a (top-left) ... bit 0 = cell i (bottom-right)
    localparam logic [7:0][8:0] LINES = {9'h1C0, 9'h038, 9'h007,
                                         9'h124, 9'h092, 9'h049,
                                         9'h111, 9'h054};

    typedef enum logic [1:0] {HUMAN_WAIT, AI_WAIT, CHECK, DONE} state_t;
    localparam state_t FIRST_ST = HUMAN_FIRST ? HUMAN_WAIT : AI_WAIT;

    function automatic logic one_hot(input logic [8:0] v);
        return (v != 9'h000) && ((v & (v - 9'd1)) == 9'h000);
    endfunction

    function automatic logic has_line(input logic [8:0] b);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 8; k++) hit = hit | ((b & LINES[k]) == LINES[k]);
        return hit;
    endfunction

    state_t          state_q, state_d;
    logic [8:0]      x_q, x_d, o_q, o_d, btn_q;
    logic [1:0]      win_q, win_d;
    logic            ill_q, ill_d, flt_q, flt_d, ai_next_q, ai_next_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [8:0]      occ, press;

    assign occ   = x_q | o_q;
    assign press = btn_i & ~btn_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i || new_game_i) begin
            state_q   <= FIRST_ST;
            x_q       <= '0;
            o_q       <= '0;
            win_q     <= WIN_NONE;
            ill_q     <= 1'b0;
            flt_q     <= 1'b0;
            ai_next_q <= 1'b0;
            tmr_q     <= '0;
            btn_q     <= btn_i;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            o_q       <= o_d;
            win_q     <= win_d;
            ill_q     <= ill_d;
            flt_q     <= flt_d;
            ai_next_q <= ai_next_d;
            tmr_q     <= tmr_d;
            btn_q     <= btn_i;
        end
    end

    // Next-state and board update
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        o_d       = o_q;
        win_d     = win_q;
        ill_d     = 1'b0;
        flt_d     = flt_q;
        ai_next_d = ai_next_q;
        tmr_d     = '0;
        case (state_q)
            HUMAN_WAIT: begin
                if (press != 9'h000) begin
                    if (one_hot(press) && ((press & occ) == 9'h000)) begin
                        x_d       = x_q | press;
                        ai_next_d = 1'b1;
                        state_d   = CHECK;
                    end else begin
                        ill_d = 1'b1;
                    end
                end
            end
            AI_WAIT: begin
                if (ai_move_i == 9'h000) begin
                    if (tmr_q >= T_LAST) begin
                        flt_d   = 1'b1;
                        win_d   = WIN_HUMAN;
                        state_d = DONE;
                    end else begin
                        tmr_d = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
                    end
                end else if (one_hot(ai_move_i) && ((ai_move_i & occ) == 9'h000)) begin
                    o_d       = o_q | ai_move_i;
                    ai_next_d = 1'b0;
                    state_d   = CHECK;
                end else begin
                    flt_d   = 1'b1;
                    win_d   = WIN_HUMAN;
                    state_d = DONE;
                end
            end
            CHECK: begin
                // X checked first so a winning move that also fills the board is a human win
                if (has_line(x_q)) begin
                    win_d   = WIN_HUMAN;
                    state_d = DONE;
                end else if (has_line(o_q)) begin
                    win_d   = WIN_AI;
                    state_d = DONE;
                end else if (occ == 9'h1FF) begin
                    win_d   = WIN_DRAW;
                    state_d = DONE;
                end else begin
                    state_d = ai_next_q ? AI_WAIT : HUMAN_WAIT;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = FIRST_ST;
            end
        endcase
    end

    // Outputs
    always_comb begin
        ai_turn_o   = (state_q == AI_WAIT);
        game_over_o = (state_q == DONE);
        x_board_o   = x_q;
        o_board_o   = o_q;
        occ_o       = occ;
        winner_o    = win_q;
        illegal_o   = ill_q;
        ai_fault_o  = flt_q;
    end

endmodule

// File: tb/tb_move_commit.sv
// Scoreboard bench for move_commit: stimulus queues each expected output change with its
// edge number; a negedge monitor pops and compares on every observed change.
module tb_move_commit;

    localparam int AI_TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_game = 1'b0;
    logic [8:0] btn = 9'h000;
    logic [8:0] ai_move = 9'h000;
    logic       ai_turn, game_over, illegal, ai_fault;
    logic [8:0] x_board, o_board, occ;
    logic [1:0] winner;

    move_commit #(.HUMAN_FIRST(1'b1), .AI_TIMEOUT(AI_TO)) dut (
        .clk_i(clk), .reset_i(reset), .new_game_i(new_game), .btn_i(btn),
        .ai_move_i(ai_move), .ai_turn_o(ai_turn), .x_board_o(x_board),
        .o_board_o(o_board), .occ_o(occ), .winner_o(winner),
        .game_over_o(game_over), .illegal_o(illegal), .ai_fault_o(ai_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] x;
        logic [8:0] o;
        logic [1:0] w;
        logic       turn, over, ill, flt;
        int         at;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   first = 1'b1;
    bit   flush = 1'b0;
    logic [23:0] prev, cur, want;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            cur = {x_board, o_board, winner, ai_turn, game_over, illegal, ai_fault};
            if (first || cur != prev) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change cyc=%0d: got x=%h o=%h w=%b turn=%b over=%b ill=%b flt=%b, required no change",
                             cyc, x_board, o_board, winner, ai_turn, game_over, illegal, ai_fault);
                end else begin
                    e = q.pop_front();
                    want = {e.x, e.o, e.w, e.turn, e.over, e.ill, e.flt};
                    if (cur != want || occ != (e.x | e.o) || (e.at >= 0 && e.at != cyc)) begin
                        n_bad++;
                        $display("FAIL %s: got x=%h o=%h occ=%h w=%b turn=%b over=%b ill=%b flt=%b cyc=%0d, required x=%h o=%h occ=%h w=%b turn=%b over=%b ill=%b flt=%b cyc=%0d",
                                 e.nm, x_board, o_board, occ, winner, ai_turn, game_over, illegal, ai_fault, cyc,
                                 e.x, e.o, e.x | e.o, e.w, e.turn, e.over, e.ill, e.flt, e.at);
                    end
                end
            end
            prev  = cur;
            first = 1'b0;
            if (flush) begin
                while (q.size() > 0) begin
                    e = q.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: got no output change, required x=%h o=%h w=%b at cyc=%0d",
                             e.nm, e.x, e.o, e.w, e.at);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] x, input logic [8:0] o, input logic [1:0] w,
                        input logic turn, input logic over, input logic ill, input logic flt,
                        input int at, input string nm);
        exp_t t;
        t.x = x; t.o = o; t.w = w; t.turn = turn; t.over = over;
        t.ill = ill; t.flt = flt; t.at = at; t.nm = nm;
        q.push_back(t);
    endtask

    task automatic press(input logic [8:0] m);
        btn = m;
        tick();
        btn = 9'h000;
        tick();
    endtask

    task automatic aimv(input logic [8:0] m);
        ai_move = m;
        tick();
        ai_move = 9'h000;
        tick();
    endtask

    task automatic newgame(input string nm);
        push(9'h000, 9'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, cyc + 1, nm);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        tick();
    endtask

    // Human opens, moves alternate; w is the hand-computed result of the final move
    task automatic game(input logic [0:8][8:0] mv, input int n, input logic [1:0] w, input string nm);
        logic [8:0] x, o;
        bit last;
        int c;
        x = 9'h000;
        o = 9'h000;
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1) && (w != 2'b00);
            c = cyc;
            if (i % 2 == 0) begin
                x = x | mv[i];
                push(x, o, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c + 1, nm);
                if (last) push(x, o, w, 1'b0, 1'b1, 1'b0, 1'b0, c + 2, nm);
                else      push(x, o, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, c + 2, nm);
                press(mv[i]);
            end else begin
                o = o | mv[i];
                push(x, o, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c + 1, nm);
                if (last) push(x, o, w, 1'b0, 1'b1, 1'b0, 1'b0, c + 2, nm);
                aimv(mv[i]);
            end
        end
    endtask

    // Opening human move of 9'h100 that hands the turn to the AI
    task automatic open_a(input string nm);
        int c;
        c = cyc;
        push(9'h100, 9'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c + 1, nm);
        push(9'h100, 9'h000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, c + 2, nm);
        press(9'h100);
    endtask

    initial begin
        int c;
        tick();
        push(9'h000, 9'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1, "reset");
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // T1/T2: human a, AI e; a held button during AI_WAIT must not count later
        open_a("t1_press");
        btn = 9'h002;
        tick();
        tick();
        c = cyc;
        push(9'h100, 9'h010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c + 1, "t2_ai_move");
        aimv(9'h010);
        tick();
        tick();
        btn = 9'h000;
        tick();

        // T3: occupied, multi-hot over occupied, multi-hot over empty
        c = cyc;
        push(9'h100, 9'h010, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, c + 1, "t3_occupied");
        push(9'h100, 9'h010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c + 2, "t3_occupied_end");
        press(9'h010);
        c = cyc;
        push(9'h100, 9'h010, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, c + 1, "t3_multi");
        push(9'h100, 9'h010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c + 2, "t3_multi_end");
        press(9'h101);
        c = cyc;
        push(9'h100, 9'h010, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, c + 1, "t3_multi_empty");
        push(9'h100, 9'h010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c + 2, "t3_multi_empty_end");
        press(9'h003);
        newgame("ng_mid_game");

        // T4: X top row; afterwards DONE ignores both inputs
        game({9'h100, 9'h020, 9'h080, 9'h010, 9'h040, 9'h000, 9'h000, 9'h000, 9'h000}, 5, 2'b01, "t4_x_row");
        btn = 9'h001;
        ai_move = 9'h001;
        repeat (4) tick();
        btn = 9'h000;
        ai_move = 9'h000;
        tick();
        newgame("t4_clear");

        game({9'h100, 9'h020, 9'h080, 9'h010, 9'h001, 9'h008, 9'h000, 9'h000, 9'h000}, 6, 2'b10, "o_mid_row");
        newgame("o_clear");

        // T5: timeout, occupied AI move, multi-hot AI move
        open_a("t5_open_to");
        push(9'h100, 9'h000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, cyc + AI_TO, "t5_timeout");
        repeat (AI_TO + 3) tick();
        newgame("t5_clear_to");
        open_a("t5_open_occ");
        push(9'h100, 9'h000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, cyc + 1, "t5_ai_occupied");
        aimv(9'h100);
        tick();
        newgame("t5_clear_occ");
        open_a("t5_open_multi");
        push(9'h100, 9'h000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, cyc + 1, "t5_ai_multi");
        aimv(9'h003);
        tick();
        newgame("t5_clear_multi");

        // T6: draw; then a full board completed by a human line scores as human win
        game({9'h100, 9'h010, 9'h040, 9'h080, 9'h002, 9'h020, 9'h008, 9'h001, 9'h004}, 9, 2'b11, "t6_draw");
        newgame("t6_clear_draw");
        game({9'h008, 9'h020, 9'h004, 9'h010, 9'h100, 9'h002, 9'h080, 9'h001, 9'h040}, 9, 2'b01, "full_x_win");
        newgame("full_clear");

        // new_game in AI_WAIT with a button held through it: no stale press afterwards
        open_a("t6_open_ai");
        push(9'h000, 9'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, cyc + 1, "t6_ng_ai_wait");
        btn = 9'h004;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        repeat (3) tick();
        btn = 9'h000;
        tick();
        c = cyc;
        push(9'h004, 9'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, c + 1, "restart_press");
        push(9'h004, 9'h000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, c + 2, "restart_turn");
        press(9'h004);
        repeat (4) tick();

        flush = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
